// File: rtl/ray_march_stepper_pkg.sv
// Shared fixed-point definitions for the ray march stepper: sign-magnitude
// component layout, vector packing and the stepper FSM encoding.
package ray_march_stepper_pkg;

   localparam int COMP_W = 19;
   localparam int MAG_W  = 18;
   localparam int VEC_W  = 3 * COMP_W;

   localparam logic [MAG_W-1:0] MAG_MAX = 18'h3FFFF;

   // Vectors are packed {x, y, z} with x in the most significant slot
   localparam int X_LSB = 2 * COMP_W;
   localparam int Y_LSB = COMP_W;
   localparam int Z_LSB = 0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADD_X  = 3'd1,
      ADD_Y  = 3'd2,
      ADD_Z  = 3'd3,
      EMIT   = 3'd4,
      FINISH = 3'd5
   } march_state_t;

endpackage

// File: rtl/ray_march_stepper_adder.sv
// Combinational sign-magnitude adder for one 19-bit component, saturating
// the magnitude instead of wrapping and never producing a negative zero.
module sm_component_adder
   import ray_march_stepper_pkg::*;
(
   input  logic [COMP_W-1:0] a,
   input  logic [COMP_W-1:0] b,
   output logic [COMP_W-1:0] sum,
   output logic              sat
);

   logic [MAG_W-1:0] mag_a;
   logic [MAG_W-1:0] mag_b;
   logic             sign_a;
   logic             sign_b;
   logic [MAG_W:0]   mag_sum;
   logic [MAG_W-1:0] mag_res;
   logic             sign_res;

   assign mag_a = a[MAG_W-1:0];
   assign mag_b = b[MAG_W-1:0];

   // A -0 operand is folded to +0 so it never steers the result sign
   assign sign_a = a[COMP_W-1] & (mag_a != '0);
   assign sign_b = b[COMP_W-1] & (mag_b != '0);

   assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

   always_comb begin
      mag_res  = '0;
      sign_res = 1'b0;
      sat      = 1'b0;
      if (sign_a == sign_b) begin
         sign_res = sign_a;
         if (mag_sum > {1'b0, MAG_MAX}) begin
            mag_res = MAG_MAX;
            sat     = 1'b1;
         end else begin
            mag_res = mag_sum[MAG_W-1:0];
         end
      end else if (mag_a >= mag_b) begin
         sign_res = sign_a;
         mag_res  = mag_a - mag_b;
      end else begin
         sign_res = sign_b;
         mag_res  = mag_b - mag_a;
      end
      if (mag_res == '0) begin
         sign_res = 1'b0;
      end
   end

   assign sum = {sign_res, mag_res};

endmodule

// File: rtl/ray_march_stepper.sv
// Ray march stepper: accumulates direction onto origin one component per cycle
// and emits step_count points over a valid/ready handshake.
module ray_march_stepper
   import ray_march_stepper_pkg::*;
#(
   parameter int STEP_W = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [VEC_W-1:0]  origin,
   input  logic [VEC_W-1:0]  direction,
   input  logic [STEP_W-1:0] step_count,
   output logic [VEC_W-1:0]  point,
   output logic              point_valid,
   input  logic              point_ready,
   output logic              done,
   output logic              sat_flag
);

   march_state_t      state;
   march_state_t      state_next;

   logic [VEC_W-1:0]  acc;
   logic [VEC_W-1:0]  dir_reg;
   logic [STEP_W-1:0] n_reg;
   logic [STEP_W-1:0] emit_count;
   logic [STEP_W:0]   count_next;

   logic [COMP_W-1:0] add_a;
   logic [COMP_W-1:0] add_b;
   logic [COMP_W-1:0] add_sum;
   logic              add_sat;

   assign count_next = {1'b0, emit_count} + {{STEP_W{1'b0}}, 1'b1};
   assign point      = acc;

   // The single adder is time-shared; the FSM state picks which axis it works on
   always_comb begin
      add_a = acc[X_LSB +: COMP_W];
      add_b = dir_reg[X_LSB +: COMP_W];
      case (state)
         ADD_Y: begin
            add_a = acc[Y_LSB +: COMP_W];
            add_b = dir_reg[Y_LSB +: COMP_W];
         end
         ADD_Z: begin
            add_a = acc[Z_LSB +: COMP_W];
            add_b = dir_reg[Z_LSB +: COMP_W];
         end
         default: ;
      endcase
   end

   sm_component_adder u_adder (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum),
      .sat (add_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      in_ready    = 1'b0;
      point_valid = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = (step_count == '0) ? FINISH : ADD_X;
            end
         end
         ADD_X:  state_next = ADD_Y;
         ADD_Y:  state_next = ADD_Z;
         ADD_Z:  state_next = EMIT;
         EMIT: begin
            point_valid = 1'b1;
            if (point_ready) begin
               state_next = (count_next < {1'b0, n_reg}) ? ADD_X : FINISH;
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Saturated components stay pinned in acc and feed the next step as-is
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc        <= '0;
         dir_reg    <= '0;
         n_reg      <= '0;
         emit_count <= '0;
         sat_flag   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc        <= origin;
                  dir_reg    <= direction;
                  n_reg      <= step_count;
                  emit_count <= '0;
                  sat_flag   <= 1'b0;
               end
            end
            ADD_X: begin
               acc[X_LSB +: COMP_W] <= add_sum;
               if (add_sat) sat_flag <= 1'b1;
            end
            ADD_Y: begin
               acc[Y_LSB +: COMP_W] <= add_sum;
               if (add_sat) sat_flag <= 1'b1;
            end
            ADD_Z: begin
               acc[Z_LSB +: COMP_W] <= add_sum;
               if (add_sat) sat_flag <= 1'b1;
            end
            EMIT: begin
               if (point_ready) emit_count <= count_next[STEP_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule
